// File: rtl/s_acq_seq.sv
// Echo acquisition sequencer: strips leading ADC samples, then writes a fixed number to the sample buffer.
// Optional ACQ_CLIP_EN adds clip_cnt, a saturating count of captured full-scale (0 or all-ones) samples.
module s_acq_seq #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              s_load,
    input  logic              s_rst,
    input  logic [15:0]       s_acqnum,
    input  logic [11:0]       s_stripnum,
    input  logic              echo_start,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              armed
`ifdef ACQ_CLIP_EN
    ,
    output logic [15:0]       clip_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, ARMED, STRIP, ACQ, DONE} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       acq_reg;
    logic [11:0]       strip_reg;
    logic [11:0]       strip_cnt_reg;
    logic [15:0]       cap_cnt_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;

    logic load_en;
    logic start_en;
    logic strip_step;
    logic cap_step;
    logic enter_done;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // s_rst overrides everything; the case below only runs when it is low.
    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        start_en   = 1'b0;
        strip_step = 1'b0;
        cap_step   = 1'b0;
        enter_done = 1'b0;
        if (s_rst) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (s_load) begin
                        load_en    = 1'b1;
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (s_load) begin
                        load_en = 1'b1;
                    end else if (echo_start) begin
                        start_en = 1'b1;
                        if (acq_reg == 16'd0) begin
                            state_next = DONE;
                            enter_done = 1'b1;
                        end else if (strip_reg != 12'd0) begin
                            state_next = STRIP;
                        end else begin
                            state_next = ACQ;
                        end
                    end
                end
                STRIP: begin
                    if (adc_valid) begin
                        strip_step = 1'b1;
                        if (strip_cnt_reg + 12'd1 == strip_reg) begin
                            state_next = ACQ;
                        end
                    end
                end
                ACQ: begin
                    if (adc_valid) begin
                        cap_step = 1'b1;
                        if (cap_cnt_reg + 16'd1 == acq_reg) begin
                            state_next = DONE;
                            enter_done = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy  = (state_reg == STRIP) || (state_reg == ACQ);
    assign armed = (state_reg == ARMED);

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            done          <= 1'b0;
            acq_reg       <= '0;
            strip_reg     <= '0;
            strip_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            addr_cnt_reg  <= '0;
        end else begin
            wr_en <= cap_step;
            done  <= enter_done;
            if (load_en) begin
                acq_reg   <= s_acqnum;
                strip_reg <= s_stripnum;
            end
            if (s_rst || start_en) begin
                strip_cnt_reg <= '0;
                cap_cnt_reg   <= '0;
                addr_cnt_reg  <= '0;
                wr_addr       <= '0;
            end
            if (strip_step) begin
                strip_cnt_reg <= strip_cnt_reg + 12'd1;
            end
            // wr_addr presents the index of the sample being written; addr_cnt_reg is the next one.
            if (cap_step) begin
                wr_data      <= adc_data;
                wr_addr      <= addr_cnt_reg;
                addr_cnt_reg <= addr_cnt_reg + 1'b1;
                cap_cnt_reg  <= cap_cnt_reg + 16'd1;
            end
        end
    end

`ifdef ACQ_CLIP_EN
    always_ff @(posedge clk_sys) begin
        if (!rst_n || s_rst || start_en) begin
            clip_cnt <= '0;
        end else if (cap_step && ((adc_data == '0) || (&adc_data)) && (clip_cnt != 16'hFFFF)) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/s_acq_seq.md
Name: s_acq_seq

Overview:
Acquisition sequencer that consumes the registered echo-acquisition controls (s_load, s_rst, s_acqnum, s_stripnum) from the acquisition-control select stage.
- On each echo window it discards s_stripnum leading ADC samples, then captures s_acqnum samples.
- Captured samples go out as write strobes, with sequential addresses, to the echo sample buffer RAM.
- It reports busy/done status to the host sequencing logic.

Parameters:
DATA_W, 12, ADC sample width
ADDR_W, 12, buffer write-address width; addresses wrap modulo 2^ADDR_W

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
s_load  in  1  load acquisition settings (level; sampled every cycle)
s_rst  in  1  synchronous abort/clear of sequencer (level)
s_acqnum  in  16  samples to capture per echo
s_stripnum  in  12  samples to discard before capture
echo_start  in  1  one-cycle pulse marking echo window start
adc_valid  in  1  ADC sample strobe
adc_data  in  DATA_W  ADC sample
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  DATA_W  buffer write data
busy  out  1  high in STRIP or ACQ
done  out  1  one-cycle pulse at end of capture
armed  out  1  high in ARMED

Behaviour:
- All logic on posedge clk_sys. rst_n=0 gives:
  - state=IDLE
  - wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, armed=0
  - latched acq/strip registers=0
- States: IDLE, ARMED, STRIP, ACQ, DONE.
- Priority per cycle: rst_n > s_rst > s_load > echo_start > adc_valid.
- s_rst=1 (any state):
  - next state IDLE; counters and wr_addr cleared.
  - wr_en forced 0 that cycle.
  - done not pulsed.
- s_load=1 in IDLE, ARMED or DONE:
  - latch s_acqnum into acq_reg and s_stripnum into strip_reg.
  - next state ARMED.
  - s_load in STRIP/ACQ is ignored; latched values unchanged.
- ARMED + echo_start (s_load=0):
  - strip_reg≠0 → STRIP, with strip counter=0.
  - strip_reg=0 → ACQ.
  - acq_reg=0 → DONE directly; no writes, done pulses.
  - wr_addr reset to 0 on every echo_start accepted in ARMED.
- STRIP: each adc_valid increments the strip counter. The adc_valid that makes count==strip_reg moves to ACQ; that sample is discarded.
- ACQ, on each adc_valid:
  - next cycle: wr_en=1, wr_data=adc_data, wr_addr = capture index (0,1,2…).
  - wr_addr increments after each write and wraps 2^ADDR_W-1 → 0.
- Capture end:
  - The adc_valid that brings the capture count to acq_reg moves the FSM to DONE.
  - The cycle after, the final wr_en and a done=1 pulse occur together.
- DONE: holds until s_load (→ARMED) or s_rst (→IDLE).
  - echo_start in DONE is ignored; re-arming needs s_load.
- echo_start in IDLE/STRIP/ACQ/DONE is ignored.
- adc_valid outside STRIP/ACQ is ignored.
- Latency: adc_valid → wr_en is exactly 1 cycle. wr_en is never high more than once per adc_valid.
- Outputs:
  - busy=1 exactly in STRIP and ACQ; armed=1 exactly in ARMED.
  - done is high for one cycle only.
- Capture count is 16-bit; acq_reg=65535 captures 65535 samples, with wr_addr wrapping.

Optional Feature:
ACQ_CLIP_EN
- Defined:
  - Adds output clip_cnt (16 bits): the number of ACQ-captured samples equal to 0 or 2^DATA_W-1.
  - clip_cnt clears on accepted echo_start, s_rst and rst_n.
  - clip_cnt saturates at 65535 and is valid when done pulses.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic capture: rst, s_load with acqnum=4, stripnum=2, echo_start, then 8 adc_valid with data 1..8.
  → wr_en 4 times with data 3,4,5,6 at addr 0..3; done pulses with the 4th wr_en; busy low afterwards.
- Zero strip / zero acq: stripnum=0, acqnum=3 → first 3 samples written.
  Then reload acqnum=0, echo_start → done the next cycle, no wr_en.
- Abort: s_rst asserted mid-ACQ after 2 writes → IDLE, no further wr_en, no done, wr_addr=0.
  A subsequent echo_start is ignored until s_load.
- Priority: s_load and echo_start in the same cycle in ARMED → stays ARMED with new values.
  s_load during ACQ → latched values unchanged and capture completes with old acqnum.
- Wrap: ADDR_W=4, acqnum=20 → addresses 0..15 then 0..3; 20 writes, one done.
- ACQ_CLIP_EN: 6 captured samples including two 0x000 and one 0xFFF → clip_cnt=3 at done.
